// File: rtl/act_pkg.sv
// Shared definitions for the ReLU6 activation-unit arbiter: FSM encoding,
// default widths and a clog2 helper for sizing requester IDs.
package act_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // Ceiling log2 with a floor of 1 so a single-bit ID is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/act_arbiter_if.sv
// Requester and activation-unit handshake bundle for act_arbiter.
//
// Handshake semantics: a requester raises req_valid[i] with its operand on
// req_data and holds both until req_ack[i] pulses for one cycle; after the ack
// the operand need not be held. rsp_valid is a one-cycle pulse qualifying
// rsp_id/rsp_data/rsp_err and carries no back-pressure. Toward the unit,
// act_start is a one-cycle pulse issued only while act_ready=1, and act_done
// is a one-cycle pulse qualifying act_result.
interface act_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      busy;
  logic                      act_start;
  logic [DATA_W-1:0]         act_data;
  logic                      act_ready;
  logic                      act_done;
  logic [DATA_W-1:0]         act_result;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, act_ready, act_done, act_result,
    output req_ack, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           act_start, act_data
  );

  // Requester / unit side.
  modport master (
    output req_valid, req_data, act_ready, act_done, act_result,
    input  req_ack, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           act_start, act_data
  );
endinterface

// File: rtl/act_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping at NUM_REQ. Reusable by any shared-unit arbiter.
module act_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W:0]        sum;

  // Rotate requests so bit 0 is rr_ptr, then scan downward so the lowest
  // rotated bit (closest to rr_ptr) is the one left in winner.
  always_comb begin
    dbl     = {req_valid, req_valid} >> rr_ptr;
    rot     = dbl[NUM_REQ-1:0];
    any_req = |req_valid;
    winner  = '0;
    sum     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        winner = sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin arbiter/sequencer sharing one ReLU6 activation unit among
// NUM_REQ requesters. One operation in flight; a watchdog turns a missing
// act_done into an error response so no requester can hang.
module act_arbiter
  import act_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = clog2(NUM_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  act_arbiter_if.slave    bus,
  output state_t          dbg_state,
  output logic [ID_W-1:0] dbg_rr_ptr
);

  localparam int WD_W = clog2(TIMEOUT);

  state_t              state, state_n;
  logic [ID_W-1:0]     rr_ptr, rr_n;
  logic [WD_W-1:0]     wd_cnt, wd_n;
  logic [ID_W-1:0]     cur_id, cur_n;
  logic [DATA_W-1:0]   op_r, op_n;
  logic [NUM_REQ-1:0]  ack_r, ack_n;
  logic                start_r, start_n;
  logic                rsp_v_r, rsp_v_n;
  logic [ID_W-1:0]     rsp_id_r, rsp_id_n;
  logic [DATA_W-1:0]   rsp_d_r, rsp_d_n;
  logic                rsp_e_r, rsp_e_n;
  logic                busy_r, busy_n;

  logic                any_req;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   req_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  act_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .any_req   (any_req),
    .winner    (winner)
  );

  // State and every output register; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      wd_cnt   <= '0;
      cur_id   <= '0;
      op_r     <= '0;
      ack_r    <= '0;
      start_r  <= 1'b0;
      rsp_v_r  <= 1'b0;
      rsp_id_r <= '0;
      rsp_d_r  <= '0;
      rsp_e_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      wd_cnt   <= wd_n;
      cur_id   <= cur_n;
      op_r     <= op_n;
      ack_r    <= ack_n;
      start_r  <= start_n;
      rsp_v_r  <= rsp_v_n;
      rsp_id_r <= rsp_id_n;
      rsp_d_r  <= rsp_d_n;
      rsp_e_r  <= rsp_e_n;
      busy_r   <= busy_n;
    end
  end

  // Next-state, grant, watchdog and response generation. Pulses default low;
  // data/ID registers hold so act_data stays stable through WAIT.
  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    wd_n     = wd_cnt;
    cur_n    = cur_id;
    op_n     = op_r;
    ack_n    = '0;
    start_n  = 1'b0;
    rsp_v_n  = 1'b0;
    rsp_id_n = rsp_id_r;
    rsp_d_n  = rsp_d_r;
    rsp_e_n  = rsp_e_r;
    case (state)
      IDLE: begin
        // Stale act_done is ignored here; grant only when the unit is idle.
        if (any_req && bus.act_ready) begin
          op_n    = req_arr[winner];
          cur_n   = winner;
          ack_n   = NUM_REQ'(1) << winner;
          start_n = 1'b1;
          rr_n    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        wd_n = wd_cnt + 1'b1;
        // A done arriving on the final watchdog cycle still counts as success.
        if (bus.act_done) begin
          rsp_v_n  = 1'b1;
          rsp_id_n = cur_id;
          rsp_d_n  = bus.act_result;
          rsp_e_n  = 1'b0;
          state_n  = IDLE;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          rsp_v_n  = 1'b1;
          rsp_id_n = cur_id;
          rsp_d_n  = '0;
          rsp_e_n  = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  assign bus.req_ack   = ack_r;
  assign bus.act_start = start_r;
  assign bus.act_data  = op_r;
  assign bus.rsp_valid = rsp_v_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_d_r;
  assign bus.rsp_err   = rsp_e_r;
  assign bus.busy      = busy_r;
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;

endmodule
